la_ioring_cfg: RTL and testbench



---
 rtl/la_ioring_cfg.sv | 132 +++++++++++++
 tb/tb_la_ioring_cfg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/la_ioring_cfg.sv
// la_ioring_cfg: power-up sequencing and serial pad-configuration loader
// for a lambda-style io ring. It drives sclk/sdata/load/ring_en on the low
// bits of the generic ioring bus and ties the upper bits to zero.
module la_ioring_cfg #(
  parameter int unsigned RINGW  = 8,
  parameter int unsigned NPADS  = 16,
  parameter int unsigned CFGW   = 4,
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned PORDLY = 16
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [NPADS*CFGW-1:0]  cfg_data,
  output logic                   busy,
  output logic                   ring_en,
  output logic [RINGW-1:0]       ioring
);

  localparam int unsigned N      = NPADS * CFGW;
  localparam int unsigned CNTMAX = (PORDLY > CLKDIV) ? PORDLY : CLKDIV;
  localparam int unsigned CW     = $clog2(CNTMAX + 1);
  localparam int unsigned BW     = $clog2(N + 1);

  typedef enum logic [1:0] {
    PWRUP,
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bit_q;
  logic [N-1:0]    sr_q;
  logic [N-1:0]    sr_shl;
  logic            sclk_q;
  logic            sdata_q;
  logic            load_q;
  logic            ring_en_q;
  logic            ready_q;
  logic            busy_q;

  // Next pad-config bit is always taken from the MSB after a left shift.
  assign sr_shl = sr_q << 1;

  // Sequencer: power-up delay, accept, MSB-first shift, load strobe.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= PWRUP;
      cnt_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      load_q    <= 1'b0;
      ring_en_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        PWRUP: begin
          if (cnt_q == CW'(PORDLY - 1)) begin
            cnt_q     <= '0;
            ring_en_q <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        IDLE: begin
          if (cfg_valid) begin
            sr_q    <= cfg_data;
            sdata_q <= cfg_data[N-1];
            bit_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != CW'(CLKDIV - 1)) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // End of a high phase: either start the next bit or go to load.
              sclk_q <= 1'b0;
              if (bit_q == BW'(N - 1)) begin
                sdata_q <= 1'b0;
                load_q  <= 1'b1;
                state_q <= LOAD;
              end else begin
                bit_q   <= bit_q + BW'(1);
                sr_q    <= sr_shl;
                sdata_q <= sr_shl[N-1];
              end
            end
          end
        end
        LOAD: begin
          if (cnt_q != CW'(CLKDIV - 1)) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q   <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= PWRUP;
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign ring_en   = ring_en_q;

  // Ring bus: low four bits carry the control signals, the rest are tied low.
  always_comb begin
    ioring      = '0;
    ioring[3:0] = {ring_en_q, load_q, sdata_q, sclk_q};
  end

endmodule

// File: tb/tb_la_ioring_cfg.sv
// Directed bench for la_ioring_cfg with NPADS=2, CFGW=4, CLKDIV=2, PORDLY=4.
module tb_la_ioring_cfg;

  logic       clk = 1'b0;
  logic       nreset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       busy;
  logic       ring_en;
  logic [7:0] ioring;

  int unsigned checks = 0;
  int unsigned errors = 0;

  la_ioring_cfg #(
    .RINGW (8),
    .NPADS (2),
    .CFGW  (4),
    .CLKDIV(2),
    .PORDLY(4)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data (cfg_data),
    .busy     (busy),
    .ring_en  (ring_en),
    .ioring   (ioring)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the accept edge; checks all 34 busy cycles and leaves
  // the bench positioned at the first idle cycle after busy falls.
  task automatic xfer(input logic [7:0] word, input string tag);
    logic [7:0]  got;
    int unsigned pulses;
    logic        prev;
    got    = '0;
    pulses = 0;
    prev   = 1'b0;
    for (int c = 0; c < 34; c++) begin
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " ready"}, cfg_ready, 1'b0);
      chk({tag, " hi"}, ioring[7:3], 5'b00001);
      if (c < 32) begin
        chk({tag, " sclk"}, ioring[0], ((c % 4) >= 2) ? 1'b1 : 1'b0);
        chk({tag, " sdata"}, ioring[1], word[7 - c / 4]);
        chk({tag, " load"}, ioring[2], 1'b0);
      end else begin
        chk({tag, " ldsclk"}, ioring[0], 1'b0);
        chk({tag, " ldsdata"}, ioring[1], 1'b0);
        chk({tag, " load"}, ioring[2], 1'b1);
      end
      if (ioring[0] && !prev) begin
        got = {got[6:0], ioring[1]};
        pulses++;
      end
      prev = ioring[0];
      tick();
    end
    chk({tag, " word"}, got, word);
    chk({tag, " pulses"}, pulses, 8);
    chk({tag, " endbusy"}, busy, 1'b0);
    chk({tag, " endready"}, cfg_ready, 1'b1);
    chk({tag, " endring"}, ioring, 8'h08);
  endtask

  // Starting just after reset release: PORDLY edges with cfg_valid pulsed.
  task automatic pwrup(input string tag);
    for (int c = 1; c <= 4; c++) begin
      cfg_valid = (c == 2);
      tick();
      chk({tag, " ring_en"}, ring_en, (c == 4) ? 1'b1 : 1'b0);
      chk({tag, " ioring"}, ioring, (c == 4) ? 8'h08 : 8'h00);
      chk({tag, " ready"}, cfg_ready, (c == 4) ? 1'b1 : 1'b0);
      chk({tag, " busy"}, busy, 1'b0);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    nreset    = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    tick();
    tick();
    chk("rst ioring", ioring, 8'h00);
    chk("rst ready", cfg_ready, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst ring_en", ring_en, 1'b0);

    // Power-up delay with an ignored cfg_valid pulse.
    nreset = 1'b1;
    pwrup("pwr1");
    tick();
    chk("pwr1 idle busy", busy, 1'b0);
    chk("pwr1 idle ioring", ioring, 8'h08);

    // Single transfer of A5.
    cfg_data  = 8'hA5;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    xfer(8'hA5, "a5");
    tick();
    chk("a5 idle busy", busy, 1'b0);

    // Back-to-back with cfg_valid held; data changes after first accept.
    cfg_data  = 8'h3C;
    cfg_valid = 1'b1;
    tick();
    cfg_data = 8'hC3;
    xfer(8'h3C, "b2b1");
    tick();
    cfg_valid = 1'b0;
    xfer(8'hC3, "b2b2");

    // Constant-level data patterns.
    cfg_data  = 8'hFF;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    xfer(8'hFF, "ones");
    tick();
    chk("ones idle sdata", ioring[1], 1'b0);
    cfg_data  = 8'h00;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    xfer(8'h00, "zeros");

    // Reset during SHIFT, partway into bit 4.
    cfg_data  = 8'hFF;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int c = 0; c < 17; c++) tick();
    chk("mid sdata", ioring[1], 1'b1);
    chk("mid busy", busy, 1'b1);
    #2 nreset = 1'b0;
    #1;
    chk("async ioring", ioring, 8'h00);
    chk("async busy", busy, 1'b0);
    chk("async ready", cfg_ready, 1'b0);
    chk("async ring_en", ring_en, 1'b0);
    tick();
    tick();
    chk("held ioring", ioring, 8'h00);
    nreset = 1'b1;
    pwrup("pwr2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
